// File: rtl/game_pkg.sv
// Shared types and constants for the dice-game phase sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        PH_START  = 3'd0,
        PH_ROLL   = 3'd1,
        PH_CHOOSE = 3'd2,
        PH_EVAL   = 3'd3,
        PH_END    = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        RES_KEPT   = 2'd0,
        RES_SCORED = 2'd1,
        RES_BUST   = 2'd2
    } choose_res_e;

    localparam logic [3:0] EN_START  = 4'b0001;
    localparam logic [3:0] EN_ROLL   = 4'b0010;
    localparam logic [3:0] EN_CHOOSE = 4'b0100;
    localparam logic [3:0] EN_END    = 4'b1000;

    // Raw code 11 has no meaning of its own and folds into KEPT.
    function automatic choose_res_e decode_res(input logic [1:0] raw);
        case (raw)
            2'b01:   return RES_SCORED;
            2'b10:   return RES_BUST;
            default: return RES_KEPT;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Stall counter for the ROLL/CHOOSE phases; expired is a combinational flag on the last cycle.
module phase_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_cnt <= '0;
        else if (clear) r_cnt <= '0;
        else if (run)   r_cnt <= r_cnt + 32'd1;
    end

    assign expired = run && (r_cnt == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/turn_scheduler.sv
// Dice-game phase sequencer: gates submodules, counts turns, judges win/loss, forfeits stalls.
module turn_scheduler
    import game_pkg::*;
#(
    parameter logic [3:0]  MAX_TURNS      = 4'd9,
    parameter logic [3:0]  WIN_SCORE      = 4'd12,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       roll_pulse,
    input  logic       choose_pulse,
    input  logic [1:0] choose_result,
    input  logic [3:0] score,
    output logic [3:0] en,
    output logic [2:0] phase,
    output logic [3:0] turns,
    output logic       won,
    output logic       lost,
    output logic       timeout,
    output logic       clr_score
);

    phase_e      r_state, w_state_nxt;
    choose_res_e r_res, w_res_nxt;
    logic [3:0]  r_turns, w_turns_nxt, w_turns_dec;
    logic        r_won, w_won_nxt;
    logic        r_lost, w_lost_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        r_clr, w_clr_nxt;
    logic        w_tmr_clear, w_tmr_run, w_expired;

    phase_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_tmr_clear),
        .run     (w_tmr_run),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= PH_START;
            r_res     <= RES_KEPT;
            r_turns   <= MAX_TURNS;
            r_won     <= 1'b0;
            r_lost    <= 1'b0;
            r_timeout <= 1'b0;
            r_clr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_res     <= w_res_nxt;
            r_turns   <= w_turns_nxt;
            r_won     <= w_won_nxt;
            r_lost    <= w_lost_nxt;
            r_timeout <= w_timeout_nxt;
            r_clr     <= w_clr_nxt;
        end
    end

    // Only the pulse belonging to the current phase is looked at, which filters strays.
    always_comb begin
        w_state_nxt   = r_state;
        w_res_nxt     = r_res;
        w_turns_nxt   = r_turns;
        w_won_nxt     = r_won;
        w_lost_nxt    = r_lost;
        w_timeout_nxt = 1'b0;
        w_clr_nxt     = 1'b0;
        w_turns_dec   = (r_turns != 4'd0) ? r_turns - 4'd1 : r_turns;
        case (r_state)
            PH_START: begin
                if (start_pulse) begin
                    w_state_nxt = PH_ROLL;
                    w_turns_nxt = MAX_TURNS;
                    w_clr_nxt   = 1'b1;
                end
            end
            PH_ROLL: begin
                if (roll_pulse) begin
                    w_state_nxt = PH_CHOOSE;
                end else if (w_expired) begin
                    w_state_nxt   = PH_EVAL;
                    w_res_nxt     = RES_KEPT;
                    w_turns_nxt   = w_turns_dec;
                    w_timeout_nxt = 1'b1;
                end
            end
            PH_CHOOSE: begin
                if (choose_pulse) begin
                    w_state_nxt = PH_EVAL;
                    w_res_nxt   = decode_res(choose_result);
                    w_turns_nxt = w_turns_dec;
                end else if (w_expired) begin
                    w_state_nxt   = PH_EVAL;
                    w_res_nxt     = RES_KEPT;
                    w_turns_nxt   = w_turns_dec;
                    w_timeout_nxt = 1'b1;
                end
            end
            PH_EVAL: begin
                w_state_nxt = PH_END;
                if (r_res == RES_BUST)       w_lost_nxt  = 1'b1;
                else if (score >= WIN_SCORE) w_won_nxt   = 1'b1;
                else if (r_turns == 4'd0)    w_lost_nxt  = 1'b1;
                else                         w_state_nxt = PH_ROLL;
            end
            PH_END: begin
                if (start_pulse) begin
                    w_state_nxt = PH_ROLL;
                    w_won_nxt   = 1'b0;
                    w_lost_nxt  = 1'b0;
                    w_turns_nxt = MAX_TURNS;
                    w_clr_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = PH_START;
        endcase
        w_tmr_run   = (r_state == PH_ROLL) || (r_state == PH_CHOOSE);
        w_tmr_clear = (w_state_nxt != r_state) &&
                      ((w_state_nxt == PH_ROLL) || (w_state_nxt == PH_CHOOSE));
    end

    always_comb begin
        case (r_state)
            PH_START:  en = EN_START;
            PH_ROLL:   en = EN_ROLL;
            PH_CHOOSE: en = EN_CHOOSE;
            PH_END:    en = EN_END | EN_START;
            default:   en = 4'b0000;
        endcase
    end

    assign phase     = r_state;
    assign turns     = r_turns;
    assign won       = r_won;
    assign lost      = r_lost;
    assign timeout   = r_timeout;
    assign clr_score = r_clr;

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Phase sequencer for the dice game. It owns game progression: it decides which of the Start, Roll and Choose submodules is enabled, consumes their completion pulses, counts down the turn budget, judges win/loss from the score register, and forces a turn forfeit when the player stalls. Its one-hot enable bus drives the submodule `enable`/`pulse_i` inputs directly, so no separate demux is needed.

## Interface
- `MAX_TURNS`, 4'd9, turn budget per game (1..15)
- `WIN_SCORE`, 4'd12, score at or above which the game is won
- `TIMEOUT_CYCLES`, 32'd500_000_000, cycles allowed in ROLL or CHOOSE before forfeit (10 s at 50 MHz); must be ≥ 2
- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `start_pulse`  in  1  single-cycle completion pulse from Start
- `roll_pulse`  in  1  single-cycle completion pulse from Roll
- `choose_pulse`  in  1  single-cycle completion pulse from Choose
- `choose_result`  in  2  valid with `choose_pulse`: 00 kept, 01 scored, 10 bust, 11 treated as 00
- `score`  in  4  current score register value
- `en`  out  4  one-hot enables: [0] Start, [1] Roll, [2] Choose, [3] end-of-game display
- `phase`  out  3  encoded state: 0 START, 1 ROLL, 2 CHOOSE, 3 EVAL, 4 END
- `turns`  out  4  turns remaining
- `won`, `lost`  out  1 each  game outcome, held through END
- `timeout`  out  1  one-cycle pulse on forfeit
- `clr_score`  out  1  one-cycle pulse when a new game begins

## Operation
- Reset values: `phase`=START, `en`=4'b0001, `turns`=MAX_TURNS, `won`=`lost`=`timeout`=`clr_score`=0, timer=0.
- START: `en`=0001. `start_pulse` → ROLL, `turns`←MAX_TURNS, `clr_score` pulses.
- ROLL: `en`=0010. `roll_pulse` → CHOOSE. Timer expiry → `timeout` pulse, `turns`−1, go to EVAL as "kept".
- CHOOSE: `en`=0100. `choose_pulse` → latch `choose_result`, `turns`−1, go to EVAL. Timer expiry → same forfeit as in ROLL.
- EVAL: `en`=0000, lasts exactly one cycle so `score` reflects the choice. Checks are applied in priority order:
  - latched bust → `lost`=1, END
  - `score` ≥ WIN_SCORE (unsigned 4-bit compare) → `won`=1, END
  - `turns`==0 → `lost`=1, END
  - otherwise → ROLL
- END: `en`=1001, so Start is re-armed alongside the display. `start_pulse` → clear `won`/`lost`, `turns`←MAX_TURNS, pulse `clr_score`, go to ROLL.
- Pulse filtering: a pulse is acted on only while its source is enabled. Pulses from disabled sources are ignored, including stray pulses arriving in the same cycle.
- `turns` never underflows: a decrement at 0 is blocked. It cannot normally occur, because EVAL ends the game at 0.
- `won` and `lost` are never both 1.

## Timing
- All state is registered. `en`, `phase`, `won` and `lost` decode only from flops, so they are glitch-free.
- A pulse sampled high at edge k changes `phase`/`en` after edge k (1-cycle latency).
- EVAL always lasts exactly one cycle. A choose completion therefore reaches ROLL or END in 2 cycles.
- Timer clears on every entry to ROLL or CHOOSE and increments each cycle in those phases. Expiry occurs on the cycle the count equals TIMEOUT_CYCLES−1.
- A completion pulse and timer expiry in the same cycle: the pulse wins and no `timeout` is raised.
- Reset asserted mid-game returns every output to its reset value immediately (asynchronous). Release is honoured at the next edge.

## Structure
- Package `game_pkg`:
  - `phase_e` enum (3-bit, values above)
  - `choose_res_e` (KEPT, SCORED, BUST)
  - `EN_START`/`EN_ROLL`/`EN_CHOOSE`/`EN_END` one-hot constants
- Sub-module `phase_timer`: 32-bit counter with `clear`, `run`, and an `expired` output.

## Test plan
- Reset, then `start_pulse` → ROLL, `en`=0010, `turns`=9, `clr_score` high for exactly 1 cycle.
- `roll_pulse`, then `choose_pulse` with result 01 and `score`=12 in EVAL → `won`=1, phase END, `en`=1001, `turns`=8.
- `choose_pulse` with result 10 → `lost`=1 after EVAL, `won`=0.
- With MAX_TURNS=2 and results 00: two full turns → `turns`=0, `lost`=1; a third `roll_pulse` in END is ignored.
- With TIMEOUT_CYCLES=8 and no pulse in CHOOSE → `timeout` pulses on the 8th cycle, `turns`−1, back to ROLL; a `choose_pulse` coincident with expiry suppresses `timeout`.
- `rst`=0 asserted mid-CHOOSE → immediate START, `en`=0001, `turns`=9; `roll_pulse` while in START is ignored.
